// File: rtl/byte_ram_pipe.sv
// Byte-lane RAM with a 1- or 2-cycle pipelined read port, write-first collision
// behaviour and out-of-range error reporting on both ports.
module byte_ram_pipe #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2**ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    i_read_req,
  input  logic [ADDR_WIDTH-1:0]   i_read_addr,
  output logic [DATA_WIDTH-1:0]   o_read_data,
  output logic                    o_read_valid,
  output logic                    o_read_err,
  input  logic                    i_write_enable,
  input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
  input  logic [ADDR_WIDTH-1:0]   i_write_addr,
  input  logic [DATA_WIDTH-1:0]   i_write_data,
  output logic                    o_wr_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  rd_in_range_s;
  logic                  wr_in_range_s;
  logic                  wr_go_s;
  logic                  addr_match_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [DATA_WIDTH-1:0] s1_data_s;

  logic s1_valid_q, s1_valid_d;
  logic s1_err_q,   s1_err_d;
  logic wr_err_q,   wr_err_d;

  assign rd_in_range_s = ({1'b0, i_read_addr}  < DEPTH_L);
  assign wr_in_range_s = ({1'b0, i_write_addr} < DEPTH_L);
  assign wr_go_s       = clk_en & i_write_enable & wr_in_range_s;
  assign addr_match_s  = (i_read_addr == i_write_addr);
  assign rd_idx_s      = i_read_addr[IDX_W-1:0];
  assign wr_idx_s      = i_write_addr[IDX_W-1:0];

  // Each lane is its own RAM with a registered read port; a same-address write
  // bypasses into that lane only, giving per-lane write-first behaviour.
  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (wr_go_s && i_byte_enable[k]) begin
        mem[wr_idx_s] <= i_write_data[8*k +: 8];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_q <= 8'h00;
      end else if (clk_en && i_read_req) begin
        if (!rd_in_range_s) begin
          lane_q <= 8'h00;
        end else if (i_write_enable && wr_in_range_s && addr_match_s && i_byte_enable[k]) begin
          lane_q <= i_write_data[8*k +: 8];
        end else begin
          lane_q <= mem[rd_idx_s];
        end
      end
    end

    assign s1_data_s[8*k +: 8] = lane_q;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_err_d   = s1_err_q;
    wr_err_d   = wr_err_q;
    if (clk_en) begin
      s1_valid_d = i_read_req;
      s1_err_d   = i_read_req & ~rd_in_range_s;
      wr_err_d   = i_write_enable & ~wr_in_range_s & (|i_byte_enable);
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign o_wr_err = wr_err_q;

  if (READ_LATENCY == 1) begin : g_lat1
    assign o_read_data  = s1_data_s;
    assign o_read_valid = s1_valid_q;
    assign o_read_err   = s1_err_q;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_err_q, s2_err_d;

    // Output stage captures only completed reads, so later writes cannot reach it.
    always_comb begin
      s2_data_d  = s2_data_q;
      s2_valid_d = s2_valid_q;
      s2_err_d   = s2_err_q;
      if (clk_en) begin
        s2_valid_d = s1_valid_q;
        s2_err_d   = s1_err_q;
        if (s1_valid_q) begin
          s2_data_d = s1_data_s;
        end else begin
          s2_data_d = s2_data_q;
        end
      end else begin
        s2_valid_d = s2_valid_q;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s2_valid_d;
        s2_err_q   <= s2_err_d;
      end
    end

    assign o_read_data  = s2_data_q;
    assign o_read_valid = s2_valid_q;
    assign o_read_err   = s2_err_q;
  end

endmodule

// File: doc/byte_ram_pipe.md
BYTE_RAM_PIPE -- requirements
Module: byte_ram_pipe

Interface
- REQ-001: Parameter ADDR_WIDTH, default 10; word-address width in bits.
- REQ-002: Parameter DATA_WIDTH, default 32; data width in bits, a multiple of 8; lanes NB = DATA_WIDTH/8.
- REQ-003: Parameter DEPTH, default 2**ADDR_WIDTH; number of implemented words, 1..2**ADDR_WIDTH.
- REQ-004: Parameter READ_LATENCY, default 1; request-to-data cycles, legal values 1 or 2 only.
- REQ-005: clk  in  1  single clock, all state updates on rising edge.
- REQ-006: rst  in  1  asynchronous, active-high reset.
- REQ-007: clk_en  in  1  global enable; low freezes all state.
- REQ-008: i_read_req  in  1  read request, accepted every cycle clk_en=1.
- REQ-009: i_read_addr  in  ADDR_WIDTH  read word address.
- REQ-010: o_read_data  out  DATA_WIDTH  read data; holds last value between reads.
- REQ-011: o_read_valid  out  1  one-cycle pulse when o_read_data updates.
- REQ-012: o_read_err  out  1  qualifies o_read_valid; set when the read address was >= DEPTH.
- REQ-013: i_write_enable  in  1  write strobe.
- REQ-014: i_byte_enable  in  NB  per-lane write mask; bit k covers data[8k+7:8k].
- REQ-015: i_write_addr  in  ADDR_WIDTH  write word address.
- REQ-016: i_write_data  in  DATA_WIDTH  write data.
- REQ-017: o_wr_err  out  1  registered one-cycle pulse; a write was dropped for address >= DEPTH.

Function
- REQ-018: Storage shall be NB independent 8-bit-wide lane arrays of DEPTH entries each, inferable as block RAM.
- REQ-019: With clk_en=1, i_write_enable=1 and i_write_addr<DEPTH, each lane k with i_byte_enable[k]=1 shall update at the edge; other lanes keep old contents.
- REQ-020: A write with i_write_addr>=DEPTH shall modify no storage and shall assert o_wr_err for exactly the next cycle.
- REQ-021: A write with i_byte_enable all zero shall modify nothing and raise no error.
- REQ-022: A read accepted at edge N shall drive o_read_data and pulse o_read_valid after edge N+READ_LATENCY-1, i.e. visible in cycle N+READ_LATENCY.
- REQ-023: READ_LATENCY=2 shall add one output register stage; back-to-back reads shall sustain one result per cycle in both modes.
- REQ-024: Read and write to the same in-range address in the same cycle shall be write-first: enabled lanes return new data, disabled lanes return stored data.
- REQ-025: In READ_LATENCY=2, a write landing on the address of a read in the output stage shall not alter that already-captured result.
- REQ-026: A read with i_read_addr>=DEPTH shall return all-zero data with o_read_err=1 on its o_read_valid pulse.
- REQ-027: o_read_err shall be 0 whenever o_read_valid=0.
- REQ-028: When no read completes, o_read_valid shall be 0 and o_read_data shall hold its previous value.
- REQ-029: With clk_en=0, storage, pipeline stage, o_read_data, o_read_valid, o_read_err and o_wr_err shall all hold; in-flight reads resume when clk_en returns high.

Reset
- REQ-030: rst=1 shall immediately clear o_read_data to 0, o_read_valid, o_read_err, o_wr_err and all pipeline valid bits, independent of clk and clk_en.
- REQ-031: Storage contents shall not be reset.
- REQ-032: Reads in flight when rst asserts shall be discarded and never produce o_read_valid.
- REQ-033: The first accepted request is the one sampled at the first rising edge after rst deasserts.

Verification
- REQ-034: Write 0xDEADBEEF to addr 5, mask all lanes; read addr 5 -> 0xDEADBEEF with o_read_valid after exactly READ_LATENCY cycles, o_read_err=0.
- REQ-035: After REQ-034, write 0x11223344 to addr 5, mask 0b0101; read -> 0xDE22BE44.
- REQ-036: Same-cycle write 0xCAFEF00D mask 0b0011 and read, addr 7 pre-loaded 0xAAAAAAAA -> read returns 0xAAAAF00D.
- REQ-037: DEPTH=16: write to addr 20 -> o_wr_err pulse, addr 4 unchanged; read addr 20 -> data 0, o_read_err=1.
- REQ-038: READ_LATENCY=2, reads addr 1,2,3 on consecutive cycles with clk_en low for one cycle mid-stream -> three results in order, no duplicate or lost o_read_valid.
- REQ-039: Assert rst with a read in flight -> outputs 0 at once, no o_read_valid after release, previously written data still readable.
